// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its serial TX controller.
// Mode codes are common to the register, the controller and the benches.
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_e;

  // MSB-first drains through bit 7 via left shifts,
  // LSB-first drains through bit 0 via right shifts.
  function automatic logic [1:0] shift_mode(input logic msb);
    return msb ? MODE_SHL : MODE_SHR;
  endfunction

  function automatic logic tap_bit(
    input logic [7:0] q,
    input logic       msb
  );
    return msb ? q[7] : q[0];
  endfunction

endpackage

// File: rtl/usr_bit_timer.sv
// Bit-period timer: div_cnt runs 0..DIV-1 while enabled.
// tick marks the last cycle of each bit period.
module usr_bit_timer #(
  parameter int DIV = 4,
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] div_cnt;

  assign tick = (div_cnt == LAST);

  // Clear wins over counting; wrap to 0 on the tick cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (clear) begin
      div_cnt <= '0;
    end else if (en) begin
      div_cnt <= tick ? '0 : div_cnt + W'(1);
    end
  end

endmodule

// File: rtl/usr_serial_tx_ctrl.sv
// Byte serializer driving a universal shift register:
// one parallel load, then eight timed shifts, tapping q for the serial bit.
module usr_serial_tx_ctrl
  import usr_pkg::*;
#(
  parameter int   DIV      = 4,
  parameter logic FILL     = 1'b0,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_msb_first,
  input  logic [7:0] q_in,
  output logic [1:0] mode,
  output logic [7:0] data_out,
  output logic       s_left,
  output logic       s_right,
  output logic       ser_out,
  output logic       ser_en,
  output logic       done
);

  tx_state_e  state_q;
  logic [7:0] byte_q;
  logic       msb_q;
  logic [2:0] bit_cnt;
  logic       tick;

  usr_bit_timer #(
    .DIV(DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(state_q == ST_LOAD),
    .en   (state_q == ST_SHIFT),
    .tick (tick)
  );

  assign data_out = byte_q;
  assign s_left   = FILL;
  assign s_right  = FILL;

  // Sequencer: accept in IDLE, load once, shift eight bit periods, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      byte_q  <= 8'h00;
      msb_q   <= 1'b0;
      bit_cnt <= 3'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            byte_q  <= in_data;
            msb_q   <= in_msb_first;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bit_cnt <= 3'd0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode from registered state, counters and q only.
  always_comb begin
    in_ready = 1'b0;
    mode     = MODE_HOLD;
    ser_en   = 1'b0;
    ser_out  = IDLE_LVL;
    done     = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        in_ready = 1'b1;
      end
      (state_q == ST_LOAD): begin
        mode = MODE_LOAD;
      end
      (state_q == ST_SHIFT): begin
        ser_en  = 1'b1;
        ser_out = tap_bit(q_in, msb_q);
        if (tick) begin
          mode = shift_mode(msb_q);
        end
      end
      (state_q == ST_DONE): begin
        done = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_serial_tx_ctrl.sv
// Directed bench: controller instances wired to behavioural shift registers.
// Instance A uses DIV=4/FILL=0, instance B uses DIV=1/FILL=1.
module tb_usr_serial_tx_ctrl;
  import usr_pkg::*;

  logic clk = 1'b0;
  logic reset;

  logic       va, ra, ma, sla, sra, soa, ena, dna;
  logic [7:0] da, qa, doa;
  logic [1:0] mda;

  logic       vb, rb, mb, slb, srb, sob, enb, dnb;
  logic [7:0] db, qb, dob;
  logic [1:0] mdb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  usr_serial_tx_ctrl #(
    .DIV(4), .FILL(1'b0), .IDLE_LVL(1'b1)
  ) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(va), .in_ready(ra),
    .in_data(da), .in_msb_first(ma),
    .q_in(qa), .mode(mda), .data_out(doa),
    .s_left(sla), .s_right(sra),
    .ser_out(soa), .ser_en(ena), .done(dna)
  );

  usr_serial_tx_ctrl #(
    .DIV(1), .FILL(1'b1), .IDLE_LVL(1'b1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(vb), .in_ready(rb),
    .in_data(db), .in_msb_first(mb),
    .q_in(qb), .mode(mdb), .data_out(dob),
    .s_left(slb), .s_right(srb),
    .ser_out(sob), .ser_en(enb), .done(dnb)
  );

  // Behavioural universal shift register for instance A
  always_ff @(posedge clk or posedge reset) begin
    if (reset) qa <= 8'h00;
    else case (mda)
      MODE_SHR:  qa <= {sra, qa[7:1]};
      MODE_SHL:  qa <= {qa[6:0], sla};
      MODE_LOAD: qa <= doa;
      default:   qa <= qa;
    endcase
  end

  // Behavioural universal shift register for instance B
  always_ff @(posedge clk or posedge reset) begin
    if (reset) qb <= 8'h00;
    else case (mdb)
      MODE_SHR:  qb <= {srb, qb[7:1]};
      MODE_SHL:  qb <= {qb[6:0], slb};
      MODE_LOAD: qb <= dob;
      default:   qb <= qb;
    endcase
  end

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Offer a byte on A; returns at the negedge of the LOAD cycle.
  task automatic offer(input logic [7:0] b, input logic msb, input string tag);
    @(negedge clk);
    va = 1'b1; da = b; ma = msb;
    chk1({tag, "_ready"}, ra, 1'b1);
    @(negedge clk);
    va = 1'b0;
  endtask

  // Called at the LOAD negedge; returns at the DONE negedge.
  task automatic stream(input logic [7:0] b, input logic msb, input string tag);
    int bad = 0;
    int shl = 0;
    int shr = 0;
    int dn = 0;
    int idx;
    logic [7:0] got = 8'h00;
    chk8({tag, "_load_mode"}, {6'd0, mda}, {6'd0, MODE_LOAD});
    chk8({tag, "_data_out"}, doa, b);
    for (int c = 2; c <= 33; c++) begin
      @(negedge clk);
      if (c == 10 || c == 20) da = ~da;
      idx = (c - 2) / 4;
      if (msb) idx = 7 - idx;
      if ((c - 2) % 4 == 1) got[idx] = soa;
      if (soa !== b[idx] || ena !== 1'b1) bad++;
      if (mda == MODE_SHL) shl++;
      if (mda == MODE_SHR) shr++;
      if (dna) dn++;
    end
    chk8({tag, "_bits"}, got, b);
    chk8({tag, "_bit_hold_errs"}, 8'(bad), 8'd0);
    chk8({tag, "_shl_cnt"}, 8'(shl), msb ? 8'd8 : 8'd0);
    chk8({tag, "_shr_cnt"}, 8'(shr), msb ? 8'd0 : 8'd8);
    chk8({tag, "_early_done"}, 8'(dn), 8'd0);
    @(negedge clk);
    chk1({tag, "_done"}, dna, 1'b1);
    chk1({tag, "_done_ready"}, ra, 1'b0);
    chk8({tag, "_done_mode"}, {6'd0, mda}, 8'd0);
    chk1({tag, "_done_en"}, ena, 1'b0);
    chk8({tag, "_q_fill"}, qa, 8'h00);
  endtask

  initial begin
    int bad;
    int sh;
    int dn;
    reset = 1'b1;
    va = 1'b0; da = 8'h00; ma = 1'b0;
    vb = 1'b0; db = 8'h00; mb = 1'b0;
    repeat (2) @(negedge clk);

    chk1("rst_ready", ra, 1'b1);
    chk8("rst_mode", {6'd0, mda}, 8'd0);
    chk8("rst_data_out", doa, 8'h00);
    chk1("rst_ser_en", ena, 1'b0);
    chk1("rst_ser_out", soa, 1'b1);
    chk1("rst_done", dna, 1'b0);
    chk1("rst_b_ready", rb, 1'b1);
    chk1("fill_a", sla, 1'b0);
    chk1("fill_b", srb, 1'b1);
    reset = 1'b0;

    // Idle for 20 cycles
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mda !== MODE_HOLD || soa !== 1'b1 || ena !== 1'b0 || ra !== 1'b1) bad++;
    end
    chk8("idle_errs", 8'(bad), 8'd0);

    // LSB-first A5
    offer(8'hA5, 1'b0, "lsb");
    stream(8'hA5, 1'b0, "lsb");
    @(negedge clk);
    chk1("lsb_ready_back", ra, 1'b1);
    chk1("lsb_done_clr", dna, 1'b0);

    // MSB-first 81
    offer(8'h81, 1'b1, "msb");
    stream(8'h81, 1'b1, "msb");
    @(negedge clk);
    chk1("msb_ready_back", ra, 1'b1);

    // Back-to-back 0F then F0 with in_valid held
    @(negedge clk);
    va = 1'b1; da = 8'h0F; ma = 1'b0;
    @(negedge clk);
    da = 8'hF0;
    stream(8'h0F, 1'b0, "b2b1");
    @(negedge clk);
    chk1("b2b_ready_35", ra, 1'b1);
    @(negedge clk);
    va = 1'b0;
    stream(8'hF0, 1'b0, "b2b2");
    @(negedge clk);

    // Reset during bit 3 of C3
    offer(8'hC3, 1'b0, "rst_mid");
    repeat (14) @(negedge clk);
    chk1("pre_rst_en", ena, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk1("mid_rst_ready", ra, 1'b1);
    chk8("mid_rst_mode", {6'd0, mda}, 8'd0);
    chk1("mid_rst_en", ena, 1'b0);
    chk1("mid_rst_ser", soa, 1'b1);
    chk8("mid_rst_data", doa, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (dna) dn++;
    end
    chk8("mid_rst_no_done", 8'(dn), 8'd0);
    offer(8'h3C, 1'b0, "after_rst");
    stream(8'h3C, 1'b0, "after_rst");
    @(negedge clk);

    // DIV=1, FILL=1 on instance B
    @(negedge clk);
    vb = 1'b1; db = 8'h00; mb = 1'b0;
    chk1("d1_ready", rb, 1'b1);
    @(negedge clk);
    vb = 1'b0;
    chk8("d1_load", {6'd0, mdb}, {6'd0, MODE_LOAD});
    bad = 0;
    sh = 0;
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      if (enb !== 1'b1 || sob !== 1'b0 || dnb !== 1'b0) bad++;
      if (mdb == MODE_SHR) sh++;
    end
    chk8("d1_shift_errs", 8'(bad), 8'd0);
    chk8("d1_shr_cnt", 8'(sh), 8'd8);
    @(negedge clk);
    chk1("d1_done", dnb, 1'b1);
    chk8("d1_q_fill", qb, 8'hFF);
    @(negedge clk);
    chk1("d1_ready_back", rb, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
